// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding.
// The transmitter imports this package for the constants only.
package uart_pkg;

    localparam int PRESCALER_W   = 21;
    localparam int PRESCALER_MIN = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Bit periods shorter than PRESCALER_MIN cannot hold a centre sample, so clamp them.
    function automatic logic [PRESCALER_W-1:0] clamp_prescaler(input logic [PRESCALER_W-1:0] p);
        if (p < PRESCALER_W'(PRESCALER_MIN)) begin
            return PRESCALER_W'(PRESCALER_MIN);
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// RX pin synchroniser (SYNC_STAGES flops, legal 2..4) followed by one extra
// flop for falling-edge detection. All flops reset to 1 so that the idle-high
// line never produces a spurious edge when reset releases.
module uart_rx_sync
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_i,
    output logic rx_s,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_d_q;

    // Shift the pin through the synchroniser chain and keep one delayed copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            rx_d_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
            rx_d_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];
    assign fall = rx_d_q & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default with a runtime-programmable bit period.
// Optional feature: define UART_RX_PARITY_EN for 8E1 frames with a parity_error strobe.
// A falling edge in idle arms a half-bit countdown to the start-bit centre; after
// that every tick lands on a bit centre. Outputs are registered single-cycle strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                   CLK,
    input  logic                   rst_n,
    input  logic                   RX,
    input  logic [PRESCALER_W-1:0] prescaler_in,
    output logic [7:0]             data,
    output logic                   rx_valid,
    output logic                   frame_error,
    output logic                   parity_error,
    output logic                   rx_active,
    output logic [2:0]             state_dbg
);

    uart_state_e            state_q, state_d;
    logic [PRESCALER_W-1:0] prescaler_q, prescaler_d;
    logic [PRESCALER_W-1:0] cnt_q, cnt_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             data_q, data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   frame_error_q, frame_error_d;
`ifdef UART_RX_PARITY_EN
    logic                   parity_bit_q, parity_bit_d;
    logic                   parity_error_q, parity_error_d;
`endif

    logic rx_s;
    logic fall;
    logic tick;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (CLK),
        .rst_n(rst_n),
        .rx_i (RX),
        .rx_s (rx_s),
        .fall (fall)
    );

    assign tick = (cnt_q == '0);

    // Next-state logic: bit-period counter, frame sequencing and output strobes.
    always_comb begin
        state_d       = state_q;
        prescaler_d   = prescaler_q;
        cnt_d         = cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        data_d        = data_q;
        rx_valid_d    = 1'b0;
        frame_error_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bit_d   = parity_bit_q;
        parity_error_d = 1'b0;
`endif

        // Outside idle the counter free-runs: tick at 0, then reload a full period.
        if (state_q != ST_IDLE) begin
            cnt_d = tick ? (prescaler_q - 1'b1) : (cnt_q - 1'b1);
        end

        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    prescaler_d = clamp_prescaler(prescaler_in);
                    cnt_d       = clamp_prescaler(prescaler_in) >> 1;
                    state_d     = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (!rx_s) begin
                        bit_cnt_d = '0;
                        state_d   = ST_DATA;
                    end else begin
                        // Line was high again at the start-bit centre: a glitch.
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    parity_bit_d = rx_s;
                    state_d      = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    if (rx_s) begin
                        data_d     = shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        frame_error_d = 1'b1;
                    end
`ifdef UART_RX_PARITY_EN
                    parity_error_d = ^{shift_q, parity_bit_q};
`endif
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            prescaler_q   <= '0;
            cnt_q         <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            data_q        <= '0;
            rx_valid_q    <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            prescaler_q   <= prescaler_d;
            cnt_q         <= cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            data_q        <= data_d;
            rx_valid_q    <= rx_valid_d;
            frame_error_q <= frame_error_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity capture and its error strobe.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            parity_bit_q   <= 1'b0;
            parity_error_q <= 1'b0;
        end else begin
            parity_bit_q   <= parity_bit_d;
            parity_error_q <= parity_error_d;
        end
    end

    assign parity_error = parity_error_q;
`else
    assign parity_error = 1'b0;
`endif

    assign data        = data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_error = frame_error_q;
    assign rx_active   = (state_q != ST_IDLE);
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx. A driver serialises frames onto RX; each frame pushes the
// outcome a UART receiver must report into exp_q. A monitor pops one entry per
// strobe and compares {parity_error, frame_error, rx_valid, data}.
module tb_uart_rx;

    localparam int EW = 11;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic [20:0] prescaler_in = 21'd104;
    logic [7:0]  data;
    logic        rx_valid;
    logic        frame_error;
    logic        parity_error;
    logic        rx_active;
    logic [2:0]  state_dbg;

    logic [EW-1:0] exp_q[$];
    logic [7:0]    last_data;
    int            n_vec = 0;
    int            n_fail = 0;

    // Clock and DUT
    always #5 clk = ~clk;

    uart_rx #(.SYNC_STAGES(2)) dut (
        .CLK         (clk),
        .rst_n       (rst_n),
        .RX          (rx),
        .prescaler_in(prescaler_in),
        .data        (data),
        .rx_valid    (rx_valid),
        .frame_error (frame_error),
        .parity_error(parity_error),
        .rx_active   (rx_active),
        .state_dbg   (state_dbg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: good stop bit -> new byte valid; bad stop -> frame error,
    // data still holds the last good byte. Parity error when byte+parity is odd.
    task automatic push_expect(input logic [7:0] b, input logic stop, input logic par);
        logic perr;
        perr = PAR_EN ? ^{b, par} : 1'b0;
        if (stop) begin
            last_data = b;
            exp_q.push_back({perr, 1'b0, 1'b1, b});
        end else begin
            exp_q.push_back({perr, 1'b1, 1'b0, last_data});
        end
    endtask

    // Driver tasks
    task automatic drive_bit(input logic v, input int cycles);
        rx = v;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input int period, input logic stop,
                              input logic par, input bit scramble);
        logic [20:0] saved;
        saved = prescaler_in;
        push_expect(b, stop, par);
        drive_bit(1'b0, period);
        if (scramble) prescaler_in = 21'($urandom_range(0, 2000));
        for (int i = 0; i < 8; i++) drive_bit(b[i], period);
`ifdef UART_RX_PARITY_EN
        drive_bit(par, period);
`endif
        drive_bit(stop, period);
        prescaler_in = saved;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Scoreboard monitor
    task automatic monitor_loop();
        logic [EW-1:0] act;
        logic [EW-1:0] exp;
        forever begin
            @(negedge clk);
            if (rx_valid || frame_error || parity_error) begin
                act = {parity_error, frame_error, rx_valid, data};
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 32'(act), 32'd0);
                end else begin
                    exp = exp_q.pop_front();
                    check("scoreboard", 32'(act), 32'(exp));
                end
            end
        end
    endtask

    initial begin
        logic [7:0] b;
        int         period;
        logic       stop;
        logic       par;

        last_data = 8'h00;
        repeat (5) @(negedge clk);
        check("reset_data", 32'(data), 32'h00);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_frame_error", 32'(frame_error), 32'd0);
        check("reset_parity_error", 32'(parity_error), 32'd0);
        check("reset_rx_active", 32'(rx_active), 32'd0);
        check("reset_state", 32'(state_dbg), 32'd0);
        rst_n = 1'b1;
        fork
            monitor_loop();
        join_none
        repeat (20) @(negedge clk);

        // Exact bit time
        send_frame(8'hA5, 104, 1'b1, ^8'hA5, 1'b0);
        drive_bit(1'b1, 104);
        wait_drain();

        // Back-to-back, no idle gap
        send_frame(8'h00, 104, 1'b1, 1'b0, 1'b0);
        send_frame(8'hFF, 104, 1'b1, 1'b0, 1'b0);
        drive_bit(1'b1, 104);
        wait_drain();

        // Short low glitch must be rejected
        drive_bit(1'b0, 30);
        drive_bit(1'b1, 200);
        check("glitch_rx_active", 32'(rx_active), 32'd0);
        check("glitch_data", 32'(data), 32'(last_data));
        wait_drain();

        // Bad stop bit, then a 20-bit break, then a good frame
        send_frame(8'h3C, 104, 1'b0, ^8'h3C, 1'b0);
        drive_bit(1'b0, 20 * 104);
        check("break_rx_active", 32'(rx_active), 32'd0);
        check("break_data", 32'(data), 32'(last_data));
        drive_bit(1'b1, 2 * 104);
        send_frame(8'h55, 104, 1'b1, ^8'h55, 1'b0);
        drive_bit(1'b1, 104);
        wait_drain();

        // Skewed bit periods (about -4% and +4%)
        send_frame(8'h96, 100, 1'b1, ^8'h96, 1'b0);
        drive_bit(1'b1, 104);
        send_frame(8'h96, 108, 1'b1, ^8'h96, 1'b0);
        drive_bit(1'b1, 104);
        wait_drain();

        // Reset in the middle of a byte
        drive_bit(1'b0, 104);
        drive_bit(1'b1, 104);
        drive_bit(1'b0, 104);
        drive_bit(1'b0, 50);
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        last_data = 8'h00;
        check("midreset_rx_active", 32'(rx_active), 32'd0);
        rst_n = 1'b1;
        drive_bit(1'b1, 2 * 104);
        check("midreset_data", 32'(data), 32'h00);
        send_frame(8'h81, 104, 1'b1, ^8'h81, 1'b0);
        drive_bit(1'b1, 104);
        wait_drain();

        // Prescaler below the minimum is clamped to 4
        prescaler_in = 21'd1;
        send_frame(8'hC3, 4, 1'b1, ^8'hC3, 1'b0);
        drive_bit(1'b1, 8);
        prescaler_in = 21'd104;
        wait_drain();

`ifdef UART_RX_PARITY_EN
        // Even parity: good and bad parity bit on the same byte
        send_frame(8'h07, 104, 1'b1, 1'b1, 1'b0);
        drive_bit(1'b1, 104);
        send_frame(8'h07, 104, 1'b1, 1'b0, 1'b0);
        drive_bit(1'b1, 104);
        wait_drain();
`endif

        // Randomised frames: skewed periods, gaps, bad stops, mid-frame prescaler changes
        for (int n = 0; n < 16; n++) begin
            b      = 8'($urandom_range(0, 255));
            period = int'($urandom_range(100, 108));
            stop   = ($urandom_range(0, 5) != 0);
            par    = ($urandom_range(0, 3) == 0) ? ~(^b) : ^b;
            send_frame(b, period, stop, par, bit'($urandom_range(0, 1)));
            if (!stop) drive_bit(1'b1, period);
            drive_bit(1'b1, int'($urandom_range(0, 2)) * period);
        end
        drive_bit(1'b1, 104);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive side of the team's 8N1 UART, paired with the existing transmitter; same runtime-programmable bit period.
- Synchronises the asynchronous RX pin and detects the start bit. Samples each bit at its centre, checks the stop bit, and presents the byte with a one-cycle valid strobe.
- Sits between the board RX pin and the user logic, such as a command parser or loopback to the transmitter.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the RX input synchroniser (legal values 2..4).

Ports:
- CLK  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- RX  input  1  serial line; idles high.
- prescaler_in  input  21  clock cycles per bit. Sampled when a start bit is detected.
- data  output  8  received byte. Holds its value until the next valid frame.
- rx_valid  output  1  one-cycle pulse: data is updated and the frame is good.
- frame_error  output  1  one-cycle pulse: the stop bit sampled low.
- parity_error  output  1  one-cycle pulse; see Optional Feature. Tied to 0 when the feature is compiled out.
- rx_active  output  1  high in every state except ST_IDLE.

Behaviour:
- Reset (async assert, sync release via CLK):
  - Registered outputs: data=0, rx_valid=0, frame_error=0, parity_error=0.
  - State: ST_IDLE, all counters 0, synchroniser flops set to 1.
  - rx_active is combinational from the state, so it is 0 in reset.
- Synchroniser: RX passes through SYNC_STAGES flops to give rx_s. An extra flop gives rx_d; a falling edge is rx_d=1 and rx_s=0.
- Prescaler latch: prescaler_in is latched into prescaler when a falling edge is seen in ST_IDLE. If the latched value is below 4, use 4. Changes to prescaler_in mid-frame are ignored.
- Bit-period counter: a 21-bit down-counter. It is loaded with the reload value and issues a tick when it reaches 0, then reloads.
- ST_IDLE:
  - On a falling edge: latch the prescaler, load the counter with prescaler>>1, go to ST_START.
- ST_START:
  - On tick: if rx_s=0, reload with prescaler-1, set bit_cnt=0, go to ST_DATA.
  - If rx_s=1 at the tick (glitch), return to ST_IDLE with no strobes.
- ST_DATA:
  - On each tick: shift rx_s in at the MSB (LSB is received first), bit_cnt+1.
  - After the 8th sample: go to ST_PARITY if the feature is enabled, else ST_STOP.
- ST_STOP, on tick:
  - rx_s=1: data <= shift register, rx_valid=1 for one cycle.
  - rx_s=0: frame_error=1, data unchanged, rx_valid=0.
  - Either way go to ST_IDLE. The next start edge may be accepted on the following cycle.
- Timing:
  - rx_valid rises at most 1 cycle after the mid-stop-bit sample tick, plus the synchroniser delay (SYNC_STAGES+1 cycles from the pin).
  - Total frame detect-to-valid is about 9.5 bit periods (10.5 with parity).
- Break condition: line held low through the stop bit gives frame_error. The block then stays in ST_IDLE until a rising edge followed by a new falling edge.
- No internal buffering: the consumer must capture data on rx_valid. An overrun is impossible to flag because data is overwritten only by the next good frame.
- Reset mid-frame aborts immediately; no strobe is issued.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame becomes 8E1. ST_PARITY samples one bit on a tick and checks even parity (XOR of data and parity bit = 0).
  - On mismatch, parity_error pulses together with the ST_STOP decision. rx_valid still pulses if the stop bit is good; data is still written.
- Undefined:
  - No ST_PARITY state; parity_error is constant 0. Frame is 8N1.

Decomposition:
- Package uart_pkg holds:
  - the state encoding (ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, 3-bit);
  - PRESCALER_W=21;
  - PRESCALER_MIN=4.
- The package is shared with the transmitter for constants only.
- One sub-module, uart_rx_sync: a parameterised SYNC_STAGES synchroniser plus edge detect. Outputs rx_s and fall.

Test Plan:
- prescaler_in=104, send 0xA5 8N1 at an exact 104-cycle bit time -> one rx_valid pulse, data=0xA5, frame_error=0.
- prescaler_in=104, back-to-back bytes 0x00 then 0xFF with no idle gap -> two rx_valid pulses in order, data 0x00 then 0xFF.
- 30-cycle low glitch on RX with prescaler 104 -> returns to idle, no strobes, data unchanged.
- Send 0x3C with the stop bit forced low -> frame_error pulse, rx_valid=0, data keeps its previous value. The line is then held low for 20 bits and a later 0x55 is received correctly.
- Bit period skewed ±4% (100 and 108 cycles) against prescaler 104, byte 0x96 -> received correctly.
- Assert rst_n low mid-byte, release, then send 0x81 -> no strobe from the aborted frame; 0x81 is received.
- With UART_RX_PARITY_EN: 0x07 sent with parity bit 1 -> rx_valid and parity_error=0. The same byte with parity bit 0 -> parity_error pulse.
